// File: rtl/cdce62002_spi_loader.sv
// CDCE62002 configuration engine: writes PLL registers 0 and 1 over SPI (LSB first),
// then reads register 0 back and flags any mismatch against the written image.
module cdce62002_spi_loader #(
   parameter int          CLK_DIV = 4,
   parameter int          CS_GAP  = 8,
   parameter logic [31:0] RD_CMD  = 32'h0000_000E
) (
   input  logic        sysclk,
   input  logic        reset_INV,
   input  logic        enable,
   input  logic        start,
   input  logic [31:0] reg0_word,
   input  logic [31:0] reg1_word,
   output logic        busy,
   output logic        done,
   output logic        verify_error,
   output logic        pll_spi_clk,
   output logic        pll_spi_mosi,
   output logic        pll_spi_cs_INV,
   input  logic        pll_spi_miso
);
   localparam int DIV_W = $clog2(CLK_DIV) + 1;
   localparam int GAP_W = $clog2(CS_GAP) + 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, GAP, FINISH} state_t;

   state_t           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [4:0]       bit_q, bit_d;
   logic [1:0]       idx_q, idx_d;
   logic [31:0]      r0_q, r0_d, r1_q, r1_d;
   logic [27:0]      cap_q, cap_d;
   logic             busy_q, busy_d, done_q, done_d, verr_q, verr_d;
   logic             sclk_q, sclk_d, mosi_q, mosi_d, csn_q, csn_d;
   logic [31:0]      word_cur;
   logic             first_bit_nxt;

   // Only readback bits [31:4] are kept: after 32 shifts they hold exactly the field compared.
   always_comb begin
      word_cur      = 32'h0;
      first_bit_nxt = 1'b0;
      unique case (idx_q)
         2'd0:    begin word_cur = r0_q;   first_bit_nxt = r1_q[0];   end
         2'd1:    begin word_cur = r1_q;   first_bit_nxt = RD_CMD[0]; end
         2'd2:    word_cur = RD_CMD;
         default: word_cur = 32'h0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      gap_d   = gap_q;
      bit_d   = bit_q;
      idx_d   = idx_q;
      r0_d    = r0_q;
      r1_d    = r1_q;
      cap_d   = cap_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      verr_d  = verr_q;
      sclk_d  = sclk_q;
      mosi_d  = mosi_q;
      csn_d   = csn_q;
      if (state_q != IDLE && !enable) begin
         state_d = IDLE;
         busy_d  = 1'b0;
         sclk_d  = 1'b0;
         mosi_d  = 1'b0;
         csn_d   = 1'b1;
      end else begin
         unique case (state_q)
            IDLE: if (start && enable) begin
               r0_d    = reg0_word;
               r1_d    = reg1_word;
               busy_d  = 1'b1;
               verr_d  = 1'b0;
               idx_d   = 2'd0;
               bit_d   = 5'd0;
               div_d   = '0;
               csn_d   = 1'b0;
               mosi_d  = reg0_word[0];
               state_d = SETUP;
            end
            SETUP, SHIFT_LO: begin
               if (div_q == DIV_LAST) begin
                  div_d   = '0;
                  sclk_d  = 1'b1;
                  state_d = SHIFT_HI;
                  if (idx_q == 2'd3) cap_d = {pll_spi_miso, cap_q[27:1]};
               end else begin
                  div_d = div_q + 1'b1;
               end
            end
            SHIFT_HI: begin
               if (div_q == DIV_LAST) begin
                  div_d  = '0;
                  sclk_d = 1'b0;
                  // The last high phase closes the word, keeping cs low for 64 half-periods.
                  if (bit_q == 5'd31) begin
                     csn_d   = 1'b1;
                     mosi_d  = 1'b0;
                     gap_d   = '0;
                     state_d = GAP;
                  end else begin
                     bit_d   = bit_q + 1'b1;
                     mosi_d  = word_cur[bit_q + 5'd1];
                     state_d = SHIFT_LO;
                  end
               end else begin
                  div_d = div_q + 1'b1;
               end
            end
            GAP: begin
               if (gap_q == GAP_LAST) begin
                  if (idx_q == 2'd3) begin
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                     state_d = FINISH;
                     if (cap_q != r0_q[31:4]) verr_d = 1'b1;
                  end else begin
                     idx_d   = idx_q + 1'b1;
                     bit_d   = 5'd0;
                     div_d   = '0;
                     csn_d   = 1'b0;
                     mosi_d  = first_bit_nxt;
                     state_d = SETUP;
                  end
               end else begin
                  gap_d = gap_q + 1'b1;
               end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge sysclk or negedge reset_INV) begin
      if (!reset_INV) begin
         state_q <= IDLE;
         div_q   <= '0;
         gap_q   <= '0;
         bit_q   <= 5'd0;
         idx_q   <= 2'd0;
         r0_q    <= 32'h0;
         r1_q    <= 32'h0;
         cap_q   <= 28'h0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         verr_q  <= 1'b0;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
         csn_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         gap_q   <= gap_d;
         bit_q   <= bit_d;
         idx_q   <= idx_d;
         r0_q    <= r0_d;
         r1_q    <= r1_d;
         cap_q   <= cap_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         verr_q  <= verr_d;
         sclk_q  <= sclk_d;
         mosi_q  <= mosi_d;
         csn_q   <= csn_d;
      end
   end

   assign busy           = busy_q;
   assign done           = done_q;
   assign verify_error   = verr_q;
   assign pll_spi_clk    = sclk_q;
   assign pll_spi_mosi   = mosi_q;
   assign pll_spi_cs_INV = csn_q;

endmodule

// File: tb/tb_cdce62002_spi_loader.sv
// Bench for cdce62002_spi_loader: two instances (4/8 and 1/1 timing), a cycle-offset
// reference model, a PLL slave that echoes a readback word, and directed plus random runs.
module tb_cdce62002_spi_loader;
   logic        sysclk = 1'b0;
   logic        rst_n  = 1'b0;
   logic        en_u   [2];
   logic        st_u   [2];
   logic        miso_u [2] = '{1'b0, 1'b0};
   logic [31:0] r0     [2];
   logic [31:0] r1     [2];
   logic        busy_u [2];
   logic        done_u [2];
   logic        verr_u [2];
   logic        sclk_u [2];
   logic        mosi_u [2];
   logic        csn_u  [2];

   int checks = 0, failures = 0, cyc = 0;

   // reference model state
   bit          act   [2];
   int          n0    [2];
   logic [31:0] w0    [2];
   logic [31:0] w1    [2];
   logic [31:0] rb    [2];
   bit          mverr [2];
   int          dcount[2];
   int          dcyc  [2];
   // PLL slave state
   int          edges [2];
   logic [31:0] rxw   [2];
   logic        pcs   [2] = '{1'b1, 1'b1};
   logic        psclk [2] = '{1'b0, 1'b0};
   logic [31:0] gq0 [$];
   logic [31:0] gq1 [$];

   always #5 sysclk = ~sysclk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      cdce62002_spi_loader #(.CLK_DIV(g == 0 ? 4 : 1), .CS_GAP(g == 0 ? 8 : 1),
                             .RD_CMD(32'h0000_000E)) u_dut (
         .sysclk(sysclk), .reset_INV(rst_n), .enable(en_u[g]), .start(st_u[g]),
         .reg0_word(r0[g]), .reg1_word(r1[g]), .busy(busy_u[g]), .done(done_u[g]),
         .verify_error(verr_u[g]), .pll_spi_clk(sclk_u[g]), .pll_spi_mosi(mosi_u[g]),
         .pll_spi_cs_INV(csn_u[g]), .pll_spi_miso(miso_u[g]));
   end

   function automatic int dv(input int i); return (i == 0) ? 4 : 1; endfunction
   function automatic int wlen(input int i); return 64 * dv(i) + ((i == 0) ? 8 : 1); endfunction
   function automatic int qsize(input int i); return (i == 0) ? gq0.size() : gq1.size(); endfunction
   function automatic logic [31:0] qword(input int i, input int k);
      if (k >= qsize(i)) return 32'hxxxx_xxxx;
      return (i == 0) ? gq0[k] : gq1[k];
   endfunction

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
      end
   endtask

   // Expected {busy, done, verify_error, sclk, mosi, cs_n} for the current cycle,
   // derived from the offset since the accepted start.
   function automatic logic [5:0] expv(input int i);
      int c, w, t, p, b;
      logic hi;
      logic [31:0] wd;
      if (!rst_n) return 6'b000001;
      if (!act[i]) return {2'b00, mverr[i], 3'b001};
      c = cyc - n0[i];
      if (c >= 4 * wlen(i)) return {2'b01, mverr[i], 3'b001};
      w = c / wlen(i);
      t = c % wlen(i);
      if (t >= 64 * dv(i)) return {2'b10, mverr[i], 3'b001};
      case (w)
         0:       wd = w0[i];
         1:       wd = w1[i];
         2:       wd = 32'h0000_000E;
         default: wd = 32'h0;
      endcase
      hi = 1'b0;
      b  = 0;
      if (t >= dv(i)) begin
         p  = (t - dv(i)) / dv(i);
         hi = (p % 2 == 0);
         b  = hi ? p / 2 : (p + 1) / 2;
      end
      return {2'b10, mverr[i], hi, wd[b], 1'b0};
   endfunction

   initial forever begin
      @(posedge sysclk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            act[i] = 0; mverr[i] = 0;
         end else if (act[i]) begin
            if (!en_u[i] || (cyc - 1 - n0[i]) == 4 * wlen(i)) act[i] = 0;
            else if (cyc - n0[i] == 4 * wlen(i))
               mverr[i] = mverr[i] | (rb[i][31:4] != w0[i][31:4]);
         end else if (st_u[i] && en_u[i]) begin
            act[i] = 1; n0[i] = cyc; w0[i] = r0[i]; w1[i] = r1[i]; mverr[i] = 0;
         end
      end
   end

   initial begin : cmp
      logic [5:0] a;
      forever begin
         @(negedge sysclk);
         for (int i = 0; i < 2; i++) begin
            a = {busy_u[i], done_u[i], verr_u[i], sclk_u[i], mosi_u[i], csn_u[i]};
            if (done_u[i] === 1'b1) begin dcount[i]++; dcyc[i] = cyc; end
            chk(i == 0 ? "cycle_dut0" : "cycle_dut1", {58'h0, a}, {58'h0, expv(i)});
         end
      end
   end

   // PLL slave: collects complete 32-edge words, serves the readback in the 4th word.
   initial forever begin
      @(negedge sysclk);
      for (int i = 0; i < 2; i++) begin
         if (csn_u[i]) begin
            if (!pcs[i] && edges[i] == 32) begin
               if (i == 0) gq0.push_back(rxw[i]); else gq1.push_back(rxw[i]);
            end
            edges[i] = 0;
         end else if (sclk_u[i] && !psclk[i]) begin
            if (edges[i] < 32) rxw[i][edges[i]] = mosi_u[i];
            edges[i]++;
         end
         pcs[i]    = csn_u[i];
         psclk[i]  = sclk_u[i];
         miso_u[i] = (!csn_u[i] && qsize(i) == 3 && edges[i] < 32) ? rb[i][edges[i]] : 1'b0;
      end
   end

   task automatic pulse_start(input int i, input bit flush, output int sc);
      @(negedge sysclk);
      if (flush) begin if (i == 0) gq0.delete(); else gq1.delete(); end
      st_u[i] = 1'b1;
      sc      = cyc;
      @(negedge sysclk);
      st_u[i] = 1'b0;
   endtask

   task automatic wait_idle(input int i);
      int n = 0;
      @(negedge sysclk);
      while (act[i] && n < 4000) begin @(negedge sysclk); n++; end
      chk("sequence_timeout", 64'(n < 4000), 64'd1);
      @(negedge sysclk);
   endtask

   task automatic check_words(input int i, input logic [31:0] a, input logic [31:0] b);
      chk("word_count", 64'(qsize(i)), 64'd4);
      chk("word0", {32'h0, qword(i, 0)}, {32'h0, a});
      chk("word1", {32'h0, qword(i, 1)}, {32'h0, b});
      chk("word2", {32'h0, qword(i, 2)}, 64'h0000_000E);
      chk("word3", {32'h0, qword(i, 3)}, 64'h0);
   endtask

   initial #5_000_000 begin
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int sc, sc2, d0, n, sel, i;
      logic [31:0] a, b;
      for (int k = 0; k < 2; k++) begin
         en_u[k] = 1'b0; st_u[k] = 1'b0; r0[k] = 32'h0; r1[k] = 32'h0; rb[k] = 32'h0;
      end
      repeat (3) @(negedge sysclk);
      chk("reset_outputs", {58'h0, busy_u[0], done_u[0], verr_u[0], sclk_u[0], mosi_u[0], csn_u[0]},
          64'b000001);
      rst_n = 1'b1;
      en_u[0] = 1'b1; en_u[1] = 1'b1;
      repeat (2) @(negedge sysclk);

      // nominal
      r0[0] = 32'h8184_0320; r1[0] = 32'h8400_0011; rb[0] = 32'h8184_0320;
      pulse_start(0, 1, sc);
      chk("busy_after_start", {63'h0, busy_u[0]}, 64'd1);
      wait_idle(0);
      chk("nominal_done_cycle", 64'(dcyc[0] - sc), 64'd1057);
      check_words(0, 32'h8184_0320, 32'h8400_0011);
      chk("nominal_verr", {63'h0, verr_u[0]}, 64'd0);

      // readback mismatch, then a clean rerun clears the flag
      rb[0] = 32'h8184_0330;
      pulse_start(0, 1, sc);
      wait_idle(0);
      chk("mismatch_done_cycle", 64'(dcyc[0] - sc), 64'd1057);
      chk("mismatch_verr", {63'h0, verr_u[0]}, 64'd1);
      rb[0] = 32'h8184_0320;
      pulse_start(0, 1, sc);
      chk("verr_cleared", {63'h0, verr_u[0]}, 64'd0);
      wait_idle(0);
      chk("verr_after_rerun", {63'h0, verr_u[0]}, 64'd0);

      // abort in word 1, bit 10 high phase
      d0 = dcount[0];
      pulse_start(0, 1, sc);
      while (cyc < sc + 1 + 264 + 84) @(negedge sysclk);
      en_u[0] = 1'b0;
      @(negedge sysclk);
      chk("abort_pins", {61'h0, csn_u[0], sclk_u[0], busy_u[0]}, 64'b100);
      en_u[0] = 1'b1;
      repeat (1200) @(negedge sysclk);
      chk("abort_no_done", 64'(dcount[0] - d0), 64'd0);
      pulse_start(0, 1, sc);
      wait_idle(0);
      check_words(0, 32'h8184_0320, 32'h8400_0011);
      chk("after_abort_done", 64'(dcount[0] - d0), 64'd1);

      // start while busy is ignored
      d0 = dcount[0];
      pulse_start(0, 1, sc);
      repeat (60) @(negedge sysclk);
      r0[0] = 32'hFFFF_FFF0;
      pulse_start(0, 0, sc2);
      wait_idle(0);
      check_words(0, 32'h8184_0320, 32'h8400_0011);
      chk("busy_start_one_done", 64'(dcount[0] - d0), 64'd1);
      chk("busy_start_done_cycle", 64'(dcyc[0] - sc), 64'd1057);

      // start in the same cycle enable falls
      @(negedge sysclk);
      st_u[0] = 1'b1; en_u[0] = 1'b0;
      @(negedge sysclk);
      st_u[0] = 1'b0;
      chk("start_with_enable_low", {63'h0, busy_u[0]}, 64'd0);
      en_u[0] = 1'b1;

      // asynchronous reset during a high SCLK phase
      r0[0] = 32'h8184_0320;
      pulse_start(0, 1, sc);
      n = 0;
      while (sclk_u[0] !== 1'b1 && n < 200) begin @(negedge sysclk); n++; end
      chk("sclk_seen", 64'(n < 200), 64'd1);
      @(posedge sysclk);
      #1 rst_n = 1'b0;
      #1 chk("async_reset_pins", {61'h0, csn_u[0], sclk_u[0], busy_u[0]}, 64'b100);
      repeat (2) @(negedge sysclk);
      rst_n = 1'b1;
      repeat (5) @(negedge sysclk);
      chk("idle_after_reset", {61'h0, csn_u[0], sclk_u[0], busy_u[0]}, 64'b100);

      // CLK_DIV=1, CS_GAP=1 corner
      r0[1] = 32'h1234_5670; r1[1] = 32'hCAFE_0001; rb[1] = 32'h1234_5670;
      pulse_start(1, 1, sc);
      wait_idle(1);
      chk("corner_done_cycle", 64'(dcyc[1] - sc), 64'd261);
      check_words(1, 32'h1234_5670, 32'hCAFE_0001);
      chk("corner_verr", {63'h0, verr_u[1]}, 64'd0);

      // randomized runs, checked cycle by cycle against the model
      for (int it = 0; it < 16; it++) begin
         i = (it % 4 == 0) ? 0 : 1;
         a = $urandom & 32'hFFFF_FFF0;
         b = ($urandom & 32'hFFFF_FFF0) | 32'h1;
         r0[i] = a; r1[i] = b;
         sel = $urandom_range(0, 2);
         case (sel)
            0:       rb[i] = a;
            1:       rb[i] = a ^ (($urandom | 32'h10) & 32'hFFFF_FFF0);
            default: rb[i] = a ^ ($urandom & 32'hF);
         endcase
         pulse_start(i, 1, sc);
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 4 * wlen(i))) @(negedge sysclk);
            en_u[i] = 1'b0;
            @(negedge sysclk);
            en_u[i] = 1'b1;
         end else if ($urandom_range(0, 2) == 0) begin
            repeat ($urandom_range(1, 4 * wlen(i) - 10)) @(negedge sysclk);
            r0[i] = $urandom;
            pulse_start(i, 0, sc2);
         end
         wait_idle(i);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
